// File: rtl/pixel_capture.sv
// pixel_capture: samples a DE/HS/VS video stream on the pixel clock, tracks
// the pixel/line position inside each frame and queues {address, colour}
// writes to a frame buffer through a 4-entry FIFO with valid/ready handshake.
// Build option: define PIXEL2X2_EN to keep only every second pixel of every
// second line and pack the colour to 12 bits (4 MSBs per channel).
module pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
`ifdef PIXEL2X2_EN
  localparam int DATA_W  = 12
`else
  localparam int DATA_W  = 24
`endif
) (
  input  logic              rfr_clk,
  input  logic              reset,
  input  logic              vid_de,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic [7:0]        vid_red,
  input  logic [7:0]        vid_green,
  input  logic [7:0]        vid_blue,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_start,
  output logic              locked,
  output logic              overflow
);

  // Counters saturate one above the active size so over-long lines/frames
  // never wrap back into range.
  localparam int PCW = $clog2(H_ACTIVE + 2);
  localparam int LCW = $clog2(V_ACTIVE + 2);
  localparam int FW  = ADDR_W + DATA_W;

  typedef enum logic [1:0] {SEEK, WAIT_DE, ACTIVE, FLUSH} state_t;

  // S1 input registers
  logic       de_q, hs_q, vs_q, vs_prev_q;
  logic [7:0] red_q, green_q, blue_q;
  logic       vs_fall;

  // frame tracking
  state_t           state_q;
  logic [PCW-1:0]   pixel_cnt_q;
  logic [LCW-1:0]   line_cnt_q;
  logic             line_err_q;
  logic             frame_start_q, locked_q;

  // pixel path
  logic [PCW-1:0]    pix_idx;
  logic              take, in_range, push, frame_ok;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  // FIFO
  logic [FW-1:0] fifo_mem_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          full, pop, push_ok, overflow_q;
  logic [FW-1:0] head;

  // Register every video input once; vs is kept one more cycle for edge detect
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      de_q      <= vid_de;
      hs_q      <= vid_hs;
      vs_q      <= vid_vs;
      vs_prev_q <= vs_q;
      red_q     <= vid_red;
      green_q   <= vid_green;
      blue_q    <= vid_blue;
    end
  end

  // Both registers reset low, so a real falling edge needs vs seen high first.
  assign vs_fall = vs_prev_q & ~vs_q;

  // Position of the S1 pixel, write decision, address and packed colour
  always_comb begin
    pix_idx  = (state_q == WAIT_DE) ? '0 : pixel_cnt_q;
    take     = de_q && !vs_fall && ((state_q == WAIT_DE) || (state_q == ACTIVE));
    in_range = (pix_idx < PCW'(H_ACTIVE)) && (line_cnt_q < LCW'(V_ACTIVE));
`ifdef PIXEL2X2_EN
    push      = take && in_range && !pix_idx[0] && !line_cnt_q[0];
    addr_full = 32'(line_cnt_q >> 1) * 32'(H_ACTIVE / 2) + 32'(pix_idx >> 1);
    push_data = {red_q[7:4], green_q[7:4], blue_q[7:4]};
`else
    push      = take && in_range;
    addr_full = 32'(line_cnt_q) * 32'(H_ACTIVE) + 32'(pix_idx);
    push_data = {red_q, green_q, blue_q};
`endif
    push_addr = addr_full[ADDR_W-1:0];
  end

  // Frame verdict at a vs edge; a line still in FLUSH is counted as finished.
  always_comb begin
    if (state_q == FLUSH)
      frame_ok = (line_cnt_q + 1'b1 == LCW'(V_ACTIVE)) && !line_err_q &&
                 (pixel_cnt_q == PCW'(H_ACTIVE));
    else
      frame_ok = (line_cnt_q == LCW'(V_ACTIVE)) && !line_err_q;
  end

  // Frame/line tracking FSM with registered frame_start and locked
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      state_q       <= SEEK;
      pixel_cnt_q   <= '0;
      line_cnt_q    <= '0;
      line_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (vs_fall) begin
        state_q       <= WAIT_DE;
        pixel_cnt_q   <= '0;
        line_cnt_q    <= '0;
        line_err_q    <= 1'b0;
        frame_start_q <= 1'b1;
        locked_q      <= (state_q != SEEK) && frame_ok;
      end else begin
        case (state_q)
          WAIT_DE: begin
            if (de_q) begin
              state_q     <= ACTIVE;
              pixel_cnt_q <= PCW'(1);
            end
          end
          ACTIVE: begin
            if (!de_q)
              state_q <= FLUSH;
            else if (pixel_cnt_q != PCW'(H_ACTIVE + 1))
              pixel_cnt_q <= pixel_cnt_q + 1'b1;
          end
          FLUSH: begin
            if (pixel_cnt_q != PCW'(H_ACTIVE))
              line_err_q <= 1'b1;
            if (line_cnt_q != LCW'(V_ACTIVE + 1))
              line_cnt_q <= line_cnt_q + 1'b1;
            pixel_cnt_q <= '0;
            state_q     <= WAIT_DE;
          end
          default: ;
        endcase
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full    = (count_q == 3'd4);
  assign pop     = wr_valid & wr_ready;
  assign push_ok = push & (!full | pop);

  // Occupancy follows accepted pushes and pops
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents only matter where the occupancy count says so
  always_ff @(posedge rfr_clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= {push_addr, push_data};
  end

  // Head entry is held until accepted; outputs read zero while empty.
  assign head        = fifo_mem_q[rd_ptr_q];
  assign wr_valid    = (count_q != 3'd0);
  assign wr_addr     = wr_valid ? head[FW-1:DATA_W] : '0;
  assign wr_data     = wr_valid ? head[DATA_W-1:0] : '0;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign overflow    = overflow_q;

  // hs carries no position information here; colour LSBs and the high
  // address product bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = &{1'b0, hs_q, addr_full, red_q[3:0], green_q[3:0], blue_q[3:0]};

endmodule

// File: tb/tb_pixel_capture.sv
// tb_pixel_capture: directed frames on an 8x4 geometry with a write monitor,
// expected-write queues and frame_start/locked/overflow/reset checks.
module tb_pixel_capture;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 6;
`ifdef PIXEL2X2_EN
  localparam int DW = 12;
`else
  localparam int DW = 24;
`endif

  logic          rfr_clk = 1'b0;
  logic          reset;
  logic          vid_de, vid_hs, vid_vs;
  logic [7:0]    vid_red, vid_green, vid_blue;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_start, locked, overflow;

  int checks = 0;
  int errors = 0;
  int cap_addr[$], cap_data[$], exp_addr[$], exp_data[$];

  pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .rfr_clk(rfr_clk), .reset(reset), .vid_de(vid_de), .vid_hs(vid_hs),
    .vid_vs(vid_vs), .vid_red(vid_red), .vid_green(vid_green),
    .vid_blue(vid_blue), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start),
    .locked(locked), .overflow(overflow)
  );

  always #5 rfr_clk = ~rfr_clk;

  // Record each accepted write, one line per transaction
  always @(negedge rfr_clk) begin
    if (!reset && wr_valid && wr_ready) begin
      cap_addr.push_back(int'(wr_addr));
      cap_data.push_back(int'(wr_data));
      $display("WR addr=%0d data=%0h", wr_addr, wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rfr_clk);
    #1;
  endtask

  // Colour driven for pixel (l,p)
  function automatic logic [23:0] pix_rgb(input int l, input int p);
`ifdef PIXEL2X2_EN
    return 24'hA53CF0;
`else
    return 24'(l * H + p);
`endif
  endfunction

  // Writes expected from a line of n pixels at line l
  task automatic add_exp(input int l, input int n);
    for (int p = 0; p < n; p++) begin
      if (p < H && l < V) begin
`ifdef PIXEL2X2_EN
        if (p % 2 == 0 && l % 2 == 0) begin
          exp_addr.push_back((l / 2) * (H / 2) + p / 2);
          exp_data.push_back(32'hA3F);
        end
`else
        exp_addr.push_back(l * H + p);
        exp_data.push_back(l * H + p);
`endif
      end
    end
  endtask

  // n pixels then a short blank with an hsync pulse
  task automatic send_line(input int l, input int n, input bit lat);
    for (int p = 0; p < n; p++) begin
      {vid_red, vid_green, vid_blue} = pix_rgb(l, p);
      vid_de = 1'b1;
      tick();
      if (lat && p == 0) check("lat_s1", wr_valid, 0);
      if (lat && p == 1) check("lat_s2", wr_valid, 1);
    end
    vid_de = 1'b0;
    vid_hs = 1'b0;
    tick();
    vid_hs = 1'b1;
    tick();
    tick();
  endtask

  // Falling vs edge; frame_start must pulse for exactly one cycle
  task automatic vs_edge(input string tag);
    int fs;
    fs = 0;
    vid_de = 1'b0;
    vid_vs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (frame_start) fs++;
    end
    check({tag, "_fs"}, fs, 1);
    vid_vs = 1'b1;
    tick();
    tick();
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_n"}, cap_addr.size(), exp_addr.size());
    n = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, cap_addr[i], exp_addr[i]);
      check({tag, "_data"}, cap_data[i], exp_data[i]);
    end
    cap_addr.delete(); cap_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  // Four lines, line sl has sn pixels, then drain
  task automatic send_frame(input string tag, input int sl, input int sn, input bit lat);
    for (int l = 0; l < V; l++) begin
      send_line(l, (l == sl) ? sn : H, lat && l == 0);
      add_exp(l, (l == sl) ? sn : H);
    end
    repeat (5) tick();
    compare_writes(tag);
  endtask

  initial begin
    reset = 1'b1; wr_ready = 1'b1;
    vid_de = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1;
    vid_red = '0; vid_green = '0; vid_blue = '0;
    repeat (3) tick();
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_fs", frame_start, 0);
    check("rst_lock", locked, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // clean frame, first write latency
    vs_edge("f1");
    check("f1_lock", locked, 0);
    send_frame("f1", -1, 0, 1'b1);

    // line 2 short
    vs_edge("f2");
    check("f2_lock", locked, 1);
    send_frame("f2", 2, 7, 1'b0);

    // line 1 too long: extra pixels not written
    vs_edge("f3");
    check("f3_lock", locked, 0);
    send_frame("f3", 1, 10, 1'b0);

    vs_edge("f4");
    check("f4_lock", locked, 0);
    send_frame("f4", -1, 0, 1'b0);

    vs_edge("f5");
    check("f5_lock", locked, 1);
`ifndef PIXEL2X2_EN
    // 8 pixels with ready low: 4 queued, 4 dropped
    send_line(0, H, 1'b0);
    add_exp(0, H);
    wr_ready = 1'b0;
    send_line(1, H, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_valid", wr_valid, 1);
    for (int i = 0; i < 3; i++) begin
      check("ovf_hold_a", wr_addr, 8);
      check("ovf_hold_d", wr_data, 8);
      tick();
    end
    wr_ready = 1'b1;
    repeat (6) tick();
    for (int a = 8; a < 12; a++) begin
      exp_addr.push_back(a);
      exp_data.push_back(a);
    end
    compare_writes("f5");
    check("ovf_sticky", overflow, 1);
`endif

    vs_edge("f6");
    check("f6_lock", locked, 0);
    send_frame("f6", -1, 0, 1'b0);

    vs_edge("f7");
    check("f7_lock", locked, 1);
`ifdef PIXEL2X2_EN
    check("f7_ovf", overflow, 0);
    wr_ready = 1'b0;
    send_line(0, 5, 1'b0);
`else
    check("f7_ovf", overflow, 1);
    wr_ready = 1'b0;
    send_line(0, 3, 1'b0);
`endif
    check("pre_rst_valid", wr_valid, 1);
    reset = 1'b1;
    tick();
    check("qrst_valid", wr_valid, 0);
    check("qrst_addr", wr_addr, 0);
    check("qrst_data", wr_data, 0);
    check("qrst_fs", frame_start, 0);
    check("qrst_lock", locked, 0);
    check("qrst_ovf", overflow, 0);
    reset = 1'b0;
    wr_ready = 1'b1;
    tick();

    // back in SEEK: a line without a vs edge produces no writes
    send_line(0, H, 1'b0);
    repeat (4) tick();
    check("seek_nowr", cap_addr.size(), 0);
    cap_addr.delete(); cap_data.delete();

    // resync in the middle of line 1
    vs_edge("f8");
    send_line(0, H, 1'b0);
    add_exp(0, H);
    for (int p = 0; p < 4; p++) begin
      {vid_red, vid_green, vid_blue} = pix_rgb(1, p);
      vid_de = 1'b1;
      tick();
    end
    add_exp(1, 4);
    vs_edge("rs");
    compare_writes("f8");
    send_line(0, H, 1'b0);
    add_exp(0, H);
    repeat (4) tick();
    compare_writes("rs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_capture.md
PIXEL_CAPTURE -- requirements
Module: pixel_capture

Interface
- REQ-001 H_ACTIVE, 640: active pixels per line.
- REQ-002 V_ACTIVE, 480: active lines per frame.
- REQ-003 ADDR_W, 19: frame-buffer write address width.
- REQ-004 rfr_clk  in  1  pixel clock; one clock, all logic on its rising edge.
- REQ-005 reset  in  1  synchronous, active-high reset.
- REQ-006 vid_de  in  1  incoming data enable; pixel valid when 1.
- REQ-007 vid_hs, vid_vs  in  1 each  incoming syncs, active-low.
- REQ-008 vid_red, vid_green, vid_blue  in  8 each  incoming pixel colour.
- REQ-009 wr_valid  out  1  frame-buffer write request.
- REQ-010 wr_ready  in  1  frame-buffer accepts; transfer when wr_valid & wr_ready.
- REQ-011 wr_addr  out  ADDR_W  write address.
- REQ-012 wr_data  out  DATA_W  packed colour; DATA_W per REQ-030/031.
- REQ-013 frame_start  out  1  one-cycle pulse on vid_vs falling edge.
- REQ-014 locked  out  1  previous frame had exactly V_ACTIVE lines of H_ACTIVE pixels.
- REQ-015 overflow  out  1  sticky: a pixel was dropped because the FIFO was full.

Function
- REQ-016 All video inputs SHALL be registered once before use; a sampled pixel is stage S1.
- REQ-017 FSM states: SEEK (wait vid_vs falling edge), WAIT_DE (between lines), ACTIVE (counting pixels), FLUSH (line ended, check length).
- REQ-018 SEEK -> WAIT_DE on registered vid_vs 1->0; pixel_cnt=0, line_cnt=0; frame_start pulses that cycle.
- REQ-019 WAIT_DE -> ACTIVE on first registered vid_de=1; that pixel is pixel_cnt=0.
- REQ-020 ACTIVE: pixel_cnt increments per de=1 cycle; de 1->0 -> FLUSH.
- REQ-021 FLUSH (one cycle): line_err set if pixel_cnt != H_ACTIVE; line_cnt increments; -> WAIT_DE.
- REQ-022 A vid_vs falling edge in any state SHALL restart at REQ-018 (resync); locked updates to 1 only if the completed frame had line_cnt==V_ACTIVE and no line_err, else 0.
- REQ-023 Pixels with pixel_cnt>=H_ACTIVE or line_cnt>=V_ACTIVE SHALL NOT be written (address never exceeds frame).
- REQ-024 Accepted pixels enter a 4-entry FIFO of {addr,data}; wr_valid = FIFO not empty; first write appears on wr_valid 2 cycles after the pixel appears on the inputs (empty FIFO).
- REQ-025 Push and pop in the same cycle SHALL both occur when FIFO full (occupancy unchanged, no drop).
- REQ-026 Push with FIFO full and no pop SHALL drop the pixel and set overflow; overflow clears only on reset.
- REQ-027 wr_addr/wr_data SHALL hold stable while wr_valid=1 and wr_ready=0.
- REQ-028 Address arithmetic SHALL be unsigned, truncated to ADDR_W.

Reset
- REQ-029 reset=1: state SEEK, counters 0, FIFO empty, wr_valid=0, wr_addr=0, wr_data=0, frame_start=0, locked=0, overflow=0; reset mid-line discards all queued writes.

Configuration
- REQ-030 PIXEL2X2_EN defined: only pixels with even pixel_cnt and even line_cnt are written; wr_addr=(line_cnt>>1)*(H_ACTIVE/2)+(pixel_cnt>>1); wr_data 12 bits = {red[7:4],green[7:4],blue[7:4]}.
- REQ-031 PIXEL2X2_EN undefined: every in-range pixel written; wr_addr=line_cnt*H_ACTIVE+pixel_cnt; wr_data 24 bits = {red,green,blue}.

Verification (bench H_ACTIVE=8, V_ACTIVE=4, ADDR_W=6)
- REQ-032 Full frame, wr_ready=1, macro off, pixel value = addr -> 32 writes, addr 0..31 in order, data==addr, locked=1 after next vs edge.
- REQ-033 Same frame, PIXEL2X2_EN on, red=8'hA5 green=8'h3C blue=8'hF0 -> 8 writes, addr 0..7, data 12'hA3F.
- REQ-034 Line 2 only 7 pixels -> writes for 7 pixels, locked=0 after next vs edge; following clean frame -> locked=1.
- REQ-035 wr_ready=0 for 8 consecutive pixels -> 4 queued, overflow=1, wr_addr/wr_data stable until ready; overflow stays 1 until reset.
- REQ-036 vid_vs falling edge mid-line 1 -> frame_start pulse, next de pixel written at addr 0.
- REQ-037 reset asserted with 3 entries queued -> next cycle wr_valid=0, all outputs 0, state SEEK.
